// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with pixel divider and programmable sync/enable delay
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLKDIV   = 2,
    parameter int PIPE     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        pix_en_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        sol_o,
    output logic        sof_o,
    output logic [15:0] frame_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    logic [15:0] div;
    logic [15:0] x_nxt;
    logic [15:0] y_nxt;
    logic        line_wrap;
    logic        frame_wrap;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        de_nxt;

    // Stage 0 holds the raw terms of the position just loaded into x/y; each
    // further stage is one pixel strobe older. Bit order is {hs, vs, de}.
    logic [2:0]  dl [PIPE+1];

    always_comb begin
        line_wrap  = (x == H_LAST);
        frame_wrap = line_wrap && (y == V_LAST);
        x_nxt      = line_wrap ? 16'd0 : x + 16'd1;
        y_nxt      = y;
        if (line_wrap) begin
            y_nxt = (y == V_LAST) ? 16'd0 : y + 16'd1;
        end
        hs_nxt = (x_nxt >= HS_START) && (x_nxt < HS_END);
        vs_nxt = (y_nxt >= VS_START) && (y_nxt < VS_END);
        de_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            div      <= 16'd0;
            x        <= 16'd0;
            y        <= 16'd0;
            frame_o  <= 16'd0;
            pix_en_o <= 1'b0;
            sol_o    <= 1'b0;
            sof_o    <= 1'b0;
            for (int i = 0; i <= PIPE; i++) begin
                dl[i] <= 3'b000;
            end
        end else if (en_i) begin
            div      <= (div == DIV_LAST) ? 16'd0 : div + 16'd1;
            pix_en_o <= (div == DIV_LAST);
            sol_o    <= pix_en_o && line_wrap;
            sof_o    <= pix_en_o && frame_wrap;
            if (pix_en_o) begin
                x     <= x_nxt;
                y     <= y_nxt;
                dl[0] <= {hs_nxt, vs_nxt, de_nxt};
                for (int i = 1; i <= PIPE; i++) begin
                    dl[i] <= dl[i-1];
                end
                if (frame_wrap) begin
                    frame_o <= frame_o + 16'd1;
                end
            end
        end else begin
            pix_en_o <= 1'b0;
            sol_o    <= 1'b0;
            sof_o    <= 1'b0;
        end
    end

    assign hsync_o = ~(dl[PIPE][2] ^ HS_ON);
    assign vsync_o = ~(dl[PIPE][1] ^ VS_ON);
    assign de_o    = dl[PIPE][0];

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - randomized and directed checks of vga_timing against a pixel-index model
module tb_vga_timing;

    typedef struct {
        int ha, hf, hw, hb;
        int va, vf, vw, vb;
        int hp, vp, cd, pp;
    } cfg_t;

    typedef struct {
        longint t;
        longint n;
        bit     pix;
        bit     sol;
        bit     sof;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state is the number of enabled edges and of pixel strobes consumed since reset.
    function automatic mdl_t mdl_step(input cfg_t c, input mdl_t m, input bit rst_n, input bit en);
        mdl_t   r;
        longint ht;
        longint vt;
        ht = c.ha + c.hf + c.hw + c.hb;
        vt = c.va + c.vf + c.vw + c.vb;
        r = m;
        r.sol = 1'b0;
        r.sof = 1'b0;
        if (!rst_n) begin
            r.t = 0; r.n = 0; r.pix = 1'b0;
        end else if (!en) begin
            r.pix = 1'b0;
        end else begin
            if (m.pix) begin
                r.n   = m.n + 1;
                r.sol = (r.n % ht) == 0;
                r.sof = r.sol && (((r.n / ht) % vt) == 0);
            end
            r.t   = m.t + 1;
            r.pix = (r.t % c.cd) == 0;
        end
        return r;
    endfunction

    function automatic logic [63:0] mdl_out(input cfg_t c, input mdl_t m);
        longint ht, vt, k, kx, ky;
        bit hs, vs, de;
        logic [15:0] ex, ey, ef;
        ht = c.ha + c.hf + c.hw + c.hb;
        vt = c.va + c.vf + c.vw + c.vb;
        ex = 16'(m.n % ht);
        ey = 16'((m.n / ht) % vt);
        ef = 16'(m.n / (ht * vt));
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        if (m.n >= longint'(c.pp + 1)) begin
            k  = m.n - c.pp;
            kx = k % ht;
            ky = (k / ht) % vt;
            hs = (kx >= c.ha + c.hf) && (kx < c.ha + c.hf + c.hw);
            vs = (ky >= c.va + c.vf) && (ky < c.va + c.vf + c.vw);
            de = (kx < c.ha) && (ky < c.va);
        end
        return {10'd0, ex, ey, ef, m.pix, m.sol, m.sof,
                hs == (c.hp != 0), vs == (c.vp != 0), de};
    endfunction

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 2};
    cfg_t cfg_b = '{20, 4, 6, 5, 10, 2, 2, 3, 1, 0, 3, 3};
    cfg_t cfg_c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 0};

    logic rst_a = 1'b0, en_a = 1'b1;
    logic rst_b = 1'b0, en_b = 1'b1;
    logic rst_c = 1'b0, en_c = 1'b1;
    logic [15:0] x_a, y_a, fr_a, x_b, y_b, fr_b, x_c, y_c, fr_c;
    logic pix_a, hs_a, vs_a, de_a, sol_a, sof_a;
    logic pix_b, hs_b, vs_b, de_b, sol_b, sof_b;
    logic pix_c, hs_c, vs_c, de_c, sol_c, sof_c;

    vga_timing u_a (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .x(x_a), .y(y_a), .pix_en_o(pix_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a), .sol_o(sol_a), .sof_o(sof_a), .frame_o(fr_a)
    );

    vga_timing #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5), .V_ACTIVE(10), .V_FP(2), .V_SYNC(2),
        .V_BP(3), .HS_POL(1), .VS_POL(0), .CLKDIV(3), .PIPE(3)
    ) u_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .x(x_b), .y(y_b), .pix_en_o(pix_b),
        .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .sol_o(sol_b), .sof_o(sof_b), .frame_o(fr_b)
    );

    vga_timing #(.CLKDIV(1), .PIPE(0)) u_c (
        .clk_i(clk), .rst_i(rst_c), .en_i(en_c), .x(x_c), .y(y_c), .pix_en_o(pix_c),
        .hsync_o(hs_c), .vsync_o(vs_c), .de_o(de_c), .sol_o(sol_c), .sof_o(sof_c), .frame_o(fr_c)
    );

    mdl_t m_a = '{0, 0, 1'b0, 1'b0, 1'b0};
    mdl_t m_b = '{0, 0, 1'b0, 1'b0, 1'b0};
    mdl_t m_c = '{0, 0, 1'b0, 1'b0, 1'b0};
    bit arm_a = 1'b0, arm_b = 1'b0, arm_c = 1'b0;

    always @(posedge clk) begin
        m_a <= mdl_step(cfg_a, m_a, rst_a, en_a);
        m_b <= mdl_step(cfg_b, m_b, rst_b, en_b);
        m_c <= mdl_step(cfg_c, m_c, rst_c, en_c);
        if (!rst_a) arm_a <= 1'b1;
        if (!rst_b) arm_b <= 1'b1;
        if (!rst_c) arm_c <= 1'b1;
    end

    always @(negedge clk) begin
        if (arm_a) check("A_model", {10'd0, x_a, y_a, fr_a, pix_a, sol_a, sof_a, hs_a, vs_a, de_a}, mdl_out(cfg_a, m_a));
        if (arm_b) check("B_model", {10'd0, x_b, y_b, fr_b, pix_b, sol_b, sof_b, hs_b, vs_b, de_b}, mdl_out(cfg_b, m_b));
        if (arm_c) check("C_model", {10'd0, x_c, y_c, fr_c, pix_c, sol_c, sof_c, hs_c, vs_c, de_c}, mdl_out(cfg_c, m_c));
    end

    initial begin
        fork
            begin : seq_a
                int k, cnt, adj;
                logic prev;
                repeat (3) @(negedge clk);
                check("A_rst_state", 64'({x_a, y_a, fr_a, hs_a, vs_a, de_a, pix_a}), 64'({48'd0, 4'b1100}));
                rst_a = 1'b1;
                cnt = 0; adj = 0; prev = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    cnt = cnt + int'(pix_a);
                    if (prev && pix_a) adj++;
                    prev = pix_a;
                end
                check("A_pix_count", 64'(cnt), 64'd20);
                check("A_pix_adjacent", 64'(adj), 64'd0);
                k = 0;
                while (k < 4000 && !(x_a == 16'd100 && pix_a)) begin @(negedge clk); k++; end
                check("A_reach_x100", 64'(x_a == 16'd100 && pix_a), 64'd1);
                en_a = 1'b0;
                repeat (37) @(negedge clk);
                check("A_stall_x", 64'(x_a), 64'd100);
                check("A_stall_pix", 64'(pix_a), 64'd0);
                check("A_stall_de", 64'(de_a), 64'd1);
                en_a = 1'b1;
                k = 0;
                do begin @(negedge clk); k++; end while (!pix_a && k < 10);
                check("A_resume_lat", 64'(k), 64'd2);
                k = 0;
                while (k < 4000 && hs_a) begin @(negedge clk); k++; end
                check("A_hs_fall_x", 64'(x_a), 64'd658);
                k = 0;
                while (k < 4000 && !(x_a == 16'd799 && y_a == 16'd0)) begin @(negedge clk); k++; end
                k = 0;
                while (k < 10 && x_a == 16'd799) begin @(negedge clk); k++; end
                check("A_wrap_xy", 64'({x_a, y_a}), 64'({16'd0, 16'd1}));
                check("A_sol_at_wrap", 64'(sol_a), 64'd1);
                k = 0;
                do begin @(negedge clk); k++; end while (!sol_a && k < 4000);
                check("A_sol_period", 64'(k), 64'd1600);
                @(negedge clk);
                check("A_sol_width", 64'(sol_a), 64'd0);
                k = 0;
                while (k < 4000 && x_a != 16'd300) begin @(negedge clk); k++; end
                rst_a = 1'b0;
                @(negedge clk);
                check("A_rst_mid", 64'({x_a, y_a, fr_a, hs_a, vs_a, de_a, pix_a}), 64'({48'd0, 4'b1100}));
                rst_a = 1'b1;
                repeat (20) @(negedge clk);
            end
            begin : seq_b
                int k;
                repeat (2) @(negedge clk);
                rst_b = 1'b1;
                k = 0;
                while (k < 3000 && vs_b) begin @(negedge clk); k++; end
                check("B_vs_pos", 64'({x_b, y_b}), 64'({16'd3, 16'd12}));
                k = 0;
                while (k < 5000 && !sof_b) begin @(negedge clk); k++; end
                check("B_sof", 64'({sof_b, x_b, y_b, fr_b}), 64'({1'b1, 16'd0, 16'd0, 16'd1}));
                repeat (30000) begin
                    @(negedge clk);
                    en_b  = ($urandom_range(0, 7) != 0);
                    rst_b = ($urandom_range(0, 2999) != 0);
                end
                rst_b = 1'b1;
                en_b  = 1'b1;
                repeat (5) @(negedge clk);
            end
            begin : seq_c
                int k, cnt;
                repeat (2) @(negedge clk);
                rst_c = 1'b1;
                @(negedge clk);
                cnt = 0;
                repeat (50) begin @(negedge clk); if (!pix_c) cnt++; end
                check("C_pix_const", 64'(cnt), 64'd0);
                k = 0;
                while (k < 2000 && !sol_c) begin @(negedge clk); k++; end
                k = 0;
                do begin @(negedge clk); k++; end while (!sol_c && k < 2000);
                check("C_line_period", 64'(k), 64'd800);
                k = 0;
                while (k < 2000 && !de_c) begin @(negedge clk); k++; end
                while (k < 4000 && de_c) begin @(negedge clk); k++; end
                check("C_de_fall_x", 64'(x_c), 64'd640);
                k = 0;
                while (k < 2000 && hs_c) begin @(negedge clk); k++; end
                check("C_hs_fall_x", 64'(x_c), 64'd656);
                cnt = 0;
                while (cnt < 2000 && !hs_c) begin @(negedge clk); cnt++; end
                check("C_hs_width", 64'(cnt), 64'd96);
                check("C_hs_rise_x", 64'(x_c), 64'd752);
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
